// File: rtl/flr_pkg.sv
// Shared FLR sequencer definitions: FSM state encoding and default parameter values.
package flr_pkg;

   localparam int FLR_NUM_FUNC      = 4;
   localparam int FLR_CNT_W         = 8;
   localparam int FLR_RESET_CYCLES  = 16;
   localparam int FLR_DRAIN_TIMEOUT = 65535;

   typedef logic [2:0] flr_state_t;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_QUIESCE = 3'd1;
   localparam logic [2:0] ST_DRAIN   = 3'd2;
   localparam logic [2:0] ST_RESET   = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/flr_outstanding_cnt.sv
// Outstanding DMA request counter for one function: saturating up, floor-at-zero down.
module flr_outstanding_cnt
   import flr_pkg::*;
#(
   parameter int CNT_W = FLR_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   input  logic clr,
   output logic zero,
   output logic underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && !dec && cnt != CNT_MAX)
         cnt <= cnt + CNT_W'(1);
      else if (dec && !inc && cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign zero      = (cnt == '0);
   // A lone retire against an empty count is a bookkeeping error upstream.
   assign underflow = dec && !inc && (cnt == '0);

endmodule

// File: rtl/flr_sequencer.sv
// Function-level-reset sequencer: serialises FLRs across functions through
// quiesce, drain, datapath reset and completion to the core.
module flr_sequencer
   import flr_pkg::*;
#(
   parameter int NUM_FUNC      = FLR_NUM_FUNC,
   parameter int CNT_W         = FLR_CNT_W,
   parameter int RESET_CYCLES  = FLR_RESET_CYCLES,
   parameter int DRAIN_TIMEOUT = FLR_DRAIN_TIMEOUT,
   localparam int FW = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1
) (
   input  logic                user_clk,
   input  logic                user_reset,
   input  logic [NUM_FUNC-1:0] flr_start,
   input  logic [NUM_FUNC-1:0] cfg_flr_in_process,
   input  logic                req_issue_valid,
   input  logic [FW-1:0]       req_issue_func,
   input  logic                cpl_retire_valid,
   input  logic [FW-1:0]       cpl_retire_func,
   output logic [NUM_FUNC-1:0] quiesce_req,
   input  logic [NUM_FUNC-1:0] quiesce_ack,
   output logic [NUM_FUNC-1:0] func_reset,
   output logic [NUM_FUNC-1:0] cfg_flr_done,
   output logic [NUM_FUNC-1:0] flr_timeout,
   output logic                cnt_err
);

   localparam int TMAX = (DRAIN_TIMEOUT > RESET_CYCLES) ? DRAIN_TIMEOUT : RESET_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);
   localparam logic [TW-1:0] RESET_LAST = TW'(RESET_CYCLES - 1);

   flr_state_t          state, state_nxt;
   logic [FW-1:0]       active, pick;
   logic                pick_vld;
   logic [NUM_FUNC-1:0] pending, pick_oh, active_oh, busy_oh;
   logic [NUM_FUNC-1:0] issue_oh, retire_oh, clr, zero, underflow;
   logic [TW-1:0]       timer;
   logic                in_proc, act_ack, act_zero, to_reset;

   for (genvar f = 0; f < NUM_FUNC; f++) begin : g_func
      assign active_oh[f] = (active == FW'(f));
      assign pick_oh[f]   = pick_vld && (state == ST_IDLE) && (pick == FW'(f));
      assign issue_oh[f]  = req_issue_valid && (req_issue_func == FW'(f));
      assign retire_oh[f] = cpl_retire_valid && (cpl_retire_func == FW'(f));

      flr_outstanding_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk       (user_clk),
         .rst       (user_reset),
         .inc       (issue_oh[f]),
         .dec       (retire_oh[f]),
         .clr       (clr[f]),
         .zero      (zero[f]),
         .underflow (underflow[f])
      );
   end

   // Lowest index wins: the loop runs high to low so the last hit sticks.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int f = NUM_FUNC - 1; f >= 0; f--) begin
         if (pending[f]) begin
            pick     = FW'(f);
            pick_vld = 1'b1;
         end
      end
   end

   assign in_proc  = |(cfg_flr_in_process & active_oh);
   assign act_ack  = |(quiesce_ack & active_oh);
   assign act_zero = |(zero & active_oh);
   assign busy_oh  = active_oh & {NUM_FUNC{state != ST_IDLE}};
   assign to_reset = (state == ST_DRAIN) && (state_nxt == ST_RESET);
   assign clr      = active_oh & {NUM_FUNC{to_reset}};

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (pick_vld) state_nxt = ST_QUIESCE;
         ST_QUIESCE: if (!in_proc) state_nxt = ST_IDLE;
                     else if (act_ack) state_nxt = ST_DRAIN;
         ST_DRAIN:   if (!in_proc) state_nxt = ST_IDLE;
                     else if (act_zero || timer == DRAIN_LAST) state_nxt = ST_RESET;
         ST_RESET:   if (!in_proc) state_nxt = ST_IDLE;
                     else if (timer == RESET_LAST) state_nxt = ST_DONE;
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state       <= ST_IDLE;
         active      <= '0;
         pending     <= '0;
         timer       <= '0;
         flr_timeout <= '0;
         cnt_err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= (pending & ~pick_oh) | (flr_start & ~pending & ~busy_oh);
         if (state == ST_IDLE && pick_vld)
            active <= pick;
         // One timer serves both the drain bound and the reset pulse length.
         timer <= (state_nxt != state) ? '0 : timer + TW'(1);
         if (to_reset && !act_zero)
            flr_timeout <= flr_timeout | active_oh;
         if (|underflow)
            cnt_err <= 1'b1;
      end
   end

   assign quiesce_req  = active_oh & {NUM_FUNC{state == ST_QUIESCE || state == ST_DRAIN ||
                                               state == ST_RESET}};
   assign func_reset   = active_oh & {NUM_FUNC{state == ST_RESET}};
   assign cfg_flr_done = active_oh & {NUM_FUNC{state == ST_DONE}};

endmodule

// File: tb/tb_flr_sequencer.sv
// Directed bench for flr_sequencer; completion pulses are checked against a queue of expected events.
module tb_flr_sequencer;

   localparam int RC = 16;
   localparam int DT = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] start, inproc, ack;
   logic       iv, rv;
   logic [1:0] ifn, rfn;
   logic [3:0] qreq, frst, done, tmo;
   logic       cerr;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int s;
   int rlen[4];

   typedef struct {int f; int c; logic t;} exp_t;
   exp_t q[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   flr_sequencer #(.NUM_FUNC(4), .CNT_W(8), .RESET_CYCLES(RC), .DRAIN_TIMEOUT(DT)) dut (
      .user_clk           (clk),
      .user_reset         (rst),
      .flr_start          (start),
      .cfg_flr_in_process (inproc),
      .req_issue_valid    (iv),
      .req_issue_func     (ifn),
      .cpl_retire_valid   (rv),
      .cpl_retire_func    (rfn),
      .quiesce_req        (qreq),
      .quiesce_ack        (ack),
      .func_reset         (frst),
      .cfg_flr_done       (done),
      .flr_timeout        (tmo),
      .cnt_err            (cerr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic issue(input logic [1:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         iv = 1'b1; ifn = f; tick();
      end
      iv = 1'b0;
   endtask

   task automatic retire(input logic [1:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         rv = 1'b1; rfn = f; tick();
      end
      rv = 1'b0;
   endtask

   task automatic start_flr(input logic [3:0] m);
      start = m; tick(); start = '0;
   endtask

   // Monitor: every done pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) rlen[i] = 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (frst[i]) rlen[i]++;
            if (done[i]) begin
               if (q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_done: func %0d at cyc %0d, none expected", i, cyc);
               end else begin
                  mon_e = q.pop_front();
                  check("done_func", i, mon_e.f);
                  check("done_cyc", cyc, mon_e.c);
                  check("done_tmo", 32'(tmo[i]), 32'(mon_e.t));
                  check("reset_len", rlen[i], RC);
               end
               rlen[i] = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish by cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = '0; inproc = '1; ack = '1;
      iv = 1'b0; rv = 1'b0; ifn = '0; rfn = '0;
      repeat (3) tick();
      check("rst_qreq", qreq, 0);
      check("rst_frst", frst, 0);
      check("rst_done", done, 0);
      check("rst_tmo", tmo, 0);
      check("rst_cerr", cerr, 0);
      rst = 1'b0;
      tick();

      // f0, nothing outstanding, ack high: done 20 cycles after start
      s = cyc; q.push_back('{0, s + 20, 1'b0}); start_flr(4'b0001);
      wait_to(s + 3);  check("t1_qreq", qreq, 4'b0001); check("t1_frst_pre", frst, 0);
      wait_to(s + 4);  check("t1_frst", frst, 4'b0001);
      wait_to(s + 19); check("t1_frst_end", frst, 4'b0001);
      wait_to(s + 20); check("t1_qreq_drop", qreq, 0);
      wait_to(s + 25);

      // f1 drains three requests retired 10 cycles apart
      issue(2'd1, 3); tick();
      s = cyc; q.push_back('{1, s + 43, 1'b0}); start_flr(4'b0010);
      wait_to(s + 5);  retire(2'd1, 1);
      wait_to(s + 15); retire(2'd1, 1);
      wait_to(s + 25); retire(2'd1, 1);
      wait_to(s + 26); check("t2_drain_frst", frst, 0); check("t2_drain_qreq", qreq, 4'b0010);
      wait_to(s + 27); check("t2_reset_entry", frst, 4'b0010);
      wait_to(s + 48); check("t2_no_tmo", tmo, 0);

      // f0 waits in quiesce until ack rises
      ack[0] = 1'b0;
      s = cyc; q.push_back('{0, s + 28, 1'b0}); start_flr(4'b0001);
      wait_to(s + 10); check("t3_wait_qreq", qreq, 4'b0001); check("t3_wait_frst", frst, 0);
      ack[0] = 1'b1;
      wait_to(s + 12); check("t3_frst", frst, 4'b0001);
      wait_to(s + 32);

      // f3 and f0 together: f0 first, duplicate f0 start ignored
      s = cyc;
      q.push_back('{0, s + 20, 1'b0});
      q.push_back('{3, s + 40, 1'b0});
      start_flr(4'b1001);
      wait_to(s + 8);  start_flr(4'b0001);
      wait_to(s + 24); check("t4_f3_frst", frst, 4'b1000);
      wait_to(s + 70);

      // f1 in_process drops during drain: abort, no done
      issue(2'd1, 1); tick();
      s = cyc; start_flr(4'b0010);
      wait_to(s + 6); check("t5_drain_qreq", qreq, 4'b0010);
      inproc[1] = 1'b0;
      tick(); check("t5_abort_qreq", qreq, 0); check("t5_abort_frst", frst, 0);
      inproc[1] = 1'b1;
      repeat (30) tick();
      retire(2'd1, 1);

      // f2 counter: issue+retire same cycle leaves count, retire at zero flags error
      issue(2'd2, 1);
      iv = 1'b1; ifn = 2'd2; rv = 1'b1; rfn = 2'd2; tick(); iv = 1'b0; rv = 1'b0;
      retire(2'd2, 1); check("t6_cerr_clear", cerr, 0);
      retire(2'd2, 1); check("t6_cerr_set", cerr, 1);
      tick();
      s = cyc; q.push_back('{2, s + 20, 1'b0}); start_flr(4'b0100);
      wait_to(s + 25);

      // f2 drain timeout with one request never retired
      issue(2'd2, 1); tick();
      s = cyc; q.push_back('{2, s + 119, 1'b1}); start_flr(4'b0100);
      wait_to(s + 102); check("t7_pre_frst", frst, 0); check("t7_pre_tmo", tmo, 0);
      wait_to(s + 103); check("t7_frst", frst, 4'b0100); check("t7_tmo", tmo, 4'b0100);
      wait_to(s + 125);
      s = cyc; q.push_back('{2, s + 20, 1'b1}); start_flr(4'b0100);
      wait_to(s + 25); check("t7_cerr_sticky", cerr, 1);

      // reset in the middle of the RESET phase abandons the sequence
      s = cyc; start_flr(4'b0001);
      wait_to(s + 8); check("t8_frst", frst, 4'b0001);
      rst = 1'b1; tick();
      check("t8_qreq", qreq, 0); check("t8_frst0", frst, 0); check("t8_done", done, 0);
      check("t8_tmo", tmo, 0); check("t8_cerr", cerr, 0);
      rst = 1'b0;
      repeat (40) tick();

      // f3 counter saturates at 255
      issue(2'd3, 260);
      retire(2'd3, 255); check("t9_sat_cerr_clear", cerr, 0);
      retire(2'd3, 1);   check("t9_sat_cerr_set", cerr, 1);
      tick();
      s = cyc; q.push_back('{3, s + 20, 1'b0}); start_flr(4'b1000);
      wait_to(s + 26);

      check("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/flr_sequencer.md
FLR_SEQUENCER -- requirements
Module: flr_sequencer

Interface
REQ-001 Parameter NUM_FUNC, default 4, number of physical functions handled.
REQ-002 Parameter CNT_W, default 8, width of the per-function outstanding-request counter.
REQ-003 Parameter RESET_CYCLES, default 16, length of the func_reset pulse in cycles.
REQ-004 Parameter DRAIN_TIMEOUT, default 65535, maximum number of DRAIN cycles before forced completion.
REQ-005 user_clk  in  1  single clock; all logic is on its rising edge.
REQ-006 user_reset  in  1  reset, synchronous and active-high.
REQ-007 flr_start  in  NUM_FUNC  one-cycle per-function FLR start pulses from the FLR edge detector.
REQ-008 cfg_flr_in_process  in  NUM_FUNC  core level per function; high while FLR is in progress.
REQ-009 req_issue_valid / req_issue_func  in  1 / 2  one DMA request issued for the function.
REQ-010 cpl_retire_valid / cpl_retire_func  in  1 / 2  one request retired (completion received) for the function.
REQ-011 quiesce_req  out  NUM_FUNC  level; user logic stops issuing new requests for the function.
REQ-012 quiesce_ack  in  NUM_FUNC  level; user logic has stopped issuing.
REQ-013 func_reset  out  NUM_FUNC  reset pulse to the per-function datapath state.
REQ-014 cfg_flr_done  out  NUM_FUNC  one-cycle completion pulse to the core.
REQ-015 flr_timeout  out  NUM_FUNC  sticky; DRAIN ended by timeout.
REQ-016 cnt_err  out  1  sticky; retire received while the counter was zero.

Function
REQ-017 The block SHALL set pending[f] on flr_start[f] unless function f is already pending or active; such duplicate starts SHALL be ignored.
REQ-018 A single FSM SHALL serve one function at a time: IDLE, QUIESCE, DRAIN, RESET, DONE.
REQ-019 IDLE -> QUIESCE when any pending bit is set; the lowest-index pending function SHALL be chosen, its pending bit cleared, and the function latched as active.
REQ-020 In QUIESCE, quiesce_req[active] SHALL be high; the FSM SHALL go to DRAIN on the first cycle quiesce_ack[active] is high.
REQ-021 In DRAIN, quiesce_req stays high; the FSM SHALL go to RESET when cnt[active]==0, or when the timeout counter reaches DRAIN_TIMEOUT (then flr_timeout[active] is set).
REQ-022 In RESET, func_reset[active] SHALL be high for exactly RESET_CYCLES cycles; cnt[active] SHALL be cleared on entry; the FSM then goes to DONE.
REQ-023 In DONE, cfg_flr_done[active] SHALL be high for one cycle, quiesce_req[active] SHALL drop, and the FSM SHALL return to IDLE.
REQ-024 Latency with zero outstanding requests and ack already high: flr_start to cfg_flr_done = RESET_CYCLES+4 cycles.
REQ-025 The counter SHALL increment on issue and decrement on retire for the matching function; issue and retire for the same function in one cycle SHALL leave it unchanged.
REQ-026 The counter SHALL saturate at 2^CNT_W-1; a retire at zero SHALL leave the count at 0 and set cnt_err.
REQ-027 Issues SHALL still be counted while quiesce_req is high.
REQ-028 If cfg_flr_in_process[active] falls before DONE, the FSM SHALL abort to IDLE next cycle, with no cfg_flr_done pulse, and drop quiesce_req and func_reset.
REQ-029 The DRAIN timeout counter SHALL reset on every DRAIN entry.
REQ-030 flr_start arriving during any state SHALL be captured as pending for a later IDLE.

Reset
REQ-031 On user_reset the block SHALL go to IDLE, clear pending, all counters, flr_timeout and cnt_err, and drive all outputs to 0.
REQ-032 Reset mid-sequence SHALL abandon the sequence with no cfg_flr_done pulse.

Structure
REQ-033 FSM state encoding and the default parameter values SHALL live in a shared package, flr_pkg.
REQ-034 Per-function counters SHALL be a sub-module, flr_outstanding_cnt, instantiated NUM_FUNC times.

Verification
REQ-035 Start on f0 with cnt=0 and ack high -> quiesce_req[0], func_reset[0] high 16 cycles, cfg_flr_done[0] pulse at cycle 20.
REQ-036 Start on f1 with cnt=3 and 3 retires spaced 10 cycles apart -> RESET entered the cycle after the count reaches 0; no timeout.
REQ-037 Start on f2 with cnt=1 and no retire, DRAIN_TIMEOUT=100 -> flr_timeout[2]=1, cfg_flr_done[2] pulses, cnt[2] becomes 0.
REQ-038 Start on f3 and f0 in the same cycle -> f0 completes first, then f3; a duplicate start on f0 mid-sequence is ignored.
REQ-039 in_process[1] drops during DRAIN -> IDLE next cycle, no done pulse; reset asserted during RESET -> all outputs 0.
REQ-040 Issue and retire for f2 in the same cycle -> count unchanged; retire at 0 -> cnt_err=1.
